clint_axi_router: RTL and testbench
===================================

// Module: clint_axi_router
// PURPOSE
//  Upstream neighbour of the CLINT: 1-master, 2-slave AXI4 address router. Decodes each
//  AW/AR address to port m0 (CLINT window), port m1 (memory window), or an internal
//  DECERR responder. Owns one outstanding write and one outstanding read, tracked
//  independently. Holds downstream valids until ready. Buffers B and R beats, so the
//  CLINT's single-cycle bvalid/rvalid pulses are never lost.
// PARAMETERS
//  CLINT_BASE  32'h02000000  m0 window base
//  CLINT_MASK  32'hFFFF0000  m0 hit: (addr & CLINT_MASK) == CLINT_BASE
//  MEM_BASE    32'h80000000  m1 window base
//  MEM_MASK    32'hF0000000  m1 hit: (addr & MEM_MASK) == MEM_BASE
// PORTS
//  aclk                     in   1   clock
//  areset                   in   1   reset; synchronous, active-high
//  s_awaddr/awvalid/awready in/in/out   32/1/1  upstream write address
//  s_wdata/wlast/wvalid     in   32/1/1         upstream write data
//  s_wready                 out  1              upstream write data ready
//  s_bresp/bvalid           out  2/1            upstream write response
//  s_bready                 in   1              upstream write response ready
//  s_araddr/arvalid         in   32/1           upstream read address
//  s_arready                out  1              upstream read address ready
//  s_rdata/rresp/rlast/rvalid out 32/2/1/1      upstream read data
//  s_rready                 in   1              upstream read data ready
//  mN_* (N=0,1)             mirror of s_* with directions reversed; m0=CLINT, m1=memory
// BEHAVIOUR
//  Reset: all *valid/*ready outputs 0, bresp/rresp=OKAY, rdata=0, rlast=0, mN_awaddr/araddr=0;
//    both FSMs return to IDLE. Reset mid-transaction drops the transaction; the
//    downstream slaves share areset.
//  Decode priority: m0 hit > m1 hit > DECERR. Evaluated only on the accept cycle.
//  Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE
//   W_IDLE: s_awready = 1. On s_awvalid, latch addr and target.
//     Next state W_ADDR, or W_DATA if target is DECERR.
//   W_ADDR: mT_awvalid = 1 with latched addr until mT_awready. Exactly one handshake.
//   W_DATA: s_wready = mT_wready; mT_wvalid = s_wvalid; wdata/wlast pass combinationally.
//     DECERR: s_wready = 1 and beats are dropped. Next state W_RESP after the s-side wlast beat.
//   B buffer (1 entry): mT_bready = ~b_held in W_DATA/W_RESP. On mT_bvalid & mT_bready,
//     capture bresp and set b_held. A bvalid pulse arriving before wlast completes
//     is still captured.
//   W_RESP: s_bvalid = b_held (DECERR: 1, bresp = 2'b11). On s_bready, clear b_held
//     and go to W_IDLE. Earliest s_bvalid is one cycle after the downstream B handshake.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE
//   R_IDLE: s_arready = 1. On s_arvalid, latch addr and target
//     (DECERR goes directly to R_DATA).
//   R_ADDR: mT_arvalid = 1 until mT_arready.
//   R_DATA: 1-entry R buffer. mT_rready = ~r_held | (s_rvalid & s_rready), giving full
//     throughput. A captured beat appears on s_r* the next cycle.
//     DECERR: single beat, rdata = 0, rresp = 2'b11, rlast = 1.
//     Exit on the s-side handshake with rlast = 1.
//  Read and write FSMs are fully independent; they may target the same port concurrently.
//  Non-selected port: all valid/ready outputs held 0.
//  Address wrap: none. Bursts are passed through; beat count comes from wlast/rlast only.
// STRUCTURE
//  clint_axi_pkg: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, target enum
//    {TGT_CLINT, TGT_MEM, TGT_ERR}, write/read state enums, decode function.
//  Sub-module clint_axi_skid: 1-entry valid/ready buffer (payload width parameterised),
//    used for the B and R paths.
// TESTING
//  1 AW 0x02000004, W 0x1 wlast -> m0_awaddr 0x02000004, m0_wdata 0x1; s_bresp 00; CLINT ipi1_m_o = 1.
//  2 AR 0x80000010, m1 returns 4 beats, s_rready toggling 1/0 -> 4 beats in order,
//    no loss/dup, rlast on beat 4 only.
//  3 AW 0x10000000, 2 W beats -> no mN valid asserted, both beats accepted, s_bresp 11 once.
//  4 AR 0x10000000 -> one beat: rdata 0, rresp 11, rlast 1; m0/m1 arvalid stay 0.
//  5 Concurrent AR CLINT + AW mem; s_bready low 5 cycles while m1 pulses bvalid
//    1 cycle -> response held, delivered once.
//  6 areset asserted in W_DATA -> next cycle all valids 0; new write to 0x02000000 completes OKAY.

Source files
------------

// File: rtl/clint_axi_pkg.sv
// Shared types for the CLINT-side AXI4 router: response codes, decode targets,
// FSM state encodings and the address decode helper.
package clint_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TGT_CLINT,
        TGT_MEM,
        TGT_ERR
    } target_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rstate_e;

    // The CLINT window wins over the memory window if the two ever overlap.
    function automatic target_e decodeTarget(
        input logic [31:0] addr,
        input logic [31:0] clintBase,
        input logic [31:0] clintMask,
        input logic [31:0] memBase,
        input logic [31:0] memMask
    );
        if ((addr & clintMask) == clintBase) begin
            return TGT_CLINT;
        end else if ((addr & memMask) == memBase) begin
            return TGT_MEM;
        end else begin
            return TGT_ERR;
        end
    endfunction

endpackage

// File: rtl/clint_axi_skid.sv
// One-entry valid/ready holding buffer; catches single-cycle response pulses
// from a downstream slave and presents them until the upstream master takes them.
module clint_axi_skid #(
    parameter int WIDTH = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             i_inValid,
    input  logic [WIDTH-1:0] i_inData,
    output logic             o_inReady,
    output logic             o_outValid,
    output logic [WIDTH-1:0] o_outData,
    input  logic             i_outReady
);

    logic             r_held;
    logic [WIDTH-1:0] r_data;

    // A new entry may replace the held one in the same cycle it drains.
    assign o_inReady  = ~r_held | i_outReady;
    assign o_outValid = r_held;
    assign o_outData  = r_data;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (i_inValid && o_inReady) begin
            r_held <= 1'b1;
            r_data <= i_inData;
        end else if (i_outReady) begin
            r_held <= 1'b0;
        end
    end

endmodule

// File: rtl/clint_axi_router.sv
// 1-master / 2-slave AXI4 address router in front of the CLINT (m0) and memory (m1),
// with an internal DECERR responder and independent single-outstanding read/write paths.
module clint_axi_router
    import clint_axi_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_MASK   = 32'hF000_0000
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [31:0] i_s_awaddr,
    input  logic        i_s_awvalid,
    output logic        o_s_awready,
    input  logic [31:0] i_s_wdata,
    input  logic        i_s_wlast,
    input  logic        i_s_wvalid,
    output logic        o_s_wready,
    output logic [1:0]  o_s_bresp,
    output logic        o_s_bvalid,
    input  logic        i_s_bready,
    input  logic [31:0] i_s_araddr,
    input  logic        i_s_arvalid,
    output logic        o_s_arready,
    output logic [31:0] o_s_rdata,
    output logic [1:0]  o_s_rresp,
    output logic        o_s_rlast,
    output logic        o_s_rvalid,
    input  logic        i_s_rready,

    output logic [31:0] o_m0_awaddr,
    output logic        o_m0_awvalid,
    input  logic        i_m0_awready,
    output logic [31:0] o_m0_wdata,
    output logic        o_m0_wlast,
    output logic        o_m0_wvalid,
    input  logic        i_m0_wready,
    input  logic [1:0]  i_m0_bresp,
    input  logic        i_m0_bvalid,
    output logic        o_m0_bready,
    output logic [31:0] o_m0_araddr,
    output logic        o_m0_arvalid,
    input  logic        i_m0_arready,
    input  logic [31:0] i_m0_rdata,
    input  logic [1:0]  i_m0_rresp,
    input  logic        i_m0_rlast,
    input  logic        i_m0_rvalid,
    output logic        o_m0_rready,

    output logic [31:0] o_m1_awaddr,
    output logic        o_m1_awvalid,
    input  logic        i_m1_awready,
    output logic [31:0] o_m1_wdata,
    output logic        o_m1_wlast,
    output logic        o_m1_wvalid,
    input  logic        i_m1_wready,
    input  logic [1:0]  i_m1_bresp,
    input  logic        i_m1_bvalid,
    output logic        o_m1_bready,
    output logic [31:0] o_m1_araddr,
    output logic        o_m1_arvalid,
    input  logic        i_m1_arready,
    input  logic [31:0] i_m1_rdata,
    input  logic [1:0]  i_m1_rresp,
    input  logic        i_m1_rlast,
    input  logic        i_m1_rvalid,
    output logic        o_m1_rready
);

    wstate_e     r_wState, w_wNext;
    rstate_e     r_rState, w_rNext;
    target_e     r_wTgt, r_rTgt;
    target_e     w_awTgt, w_arTgt;
    logic [31:0] r_awAddr, r_arAddr;

    logic        w_awValid, w_wValid, w_bPhase, w_bOutReady;
    logic        w_arValid, w_rPhase, w_rOutReady;
    logic        w_awReadySel, w_wReadySel, w_bValidSel, w_arReadySel, w_rValidSel;
    logic [1:0]  w_bRespSel;
    logic [34:0] w_rBeatSel;
    logic        w_bReadyPre, w_bHeld, w_bInReady;
    logic [1:0]  w_bData;
    logic        w_rReadyPre, w_rHeld, w_rInReady;
    logic [34:0] w_rBufData;

    assign w_awTgt = decodeTarget(i_s_awaddr, CLINT_BASE, CLINT_MASK, MEM_BASE, MEM_MASK);
    assign w_arTgt = decodeTarget(i_s_araddr, CLINT_BASE, CLINT_MASK, MEM_BASE, MEM_MASK);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wState <= W_IDLE;
            r_wTgt   <= TGT_CLINT;
            r_awAddr <= '0;
            r_rState <= R_IDLE;
            r_rTgt   <= TGT_CLINT;
            r_arAddr <= '0;
        end else begin
            r_wState <= w_wNext;
            r_rState <= w_rNext;
            if (r_wState == W_IDLE && i_s_awvalid) begin
                r_wTgt   <= w_awTgt;
                r_awAddr <= i_s_awaddr;
            end
            if (r_rState == R_IDLE && i_s_arvalid) begin
                r_rTgt   <= w_arTgt;
                r_arAddr <= i_s_araddr;
            end
        end
    end

    // Select the downstream handshake inputs belonging to the latched targets.
    assign w_awReadySel = (r_wTgt == TGT_CLINT) ? i_m0_awready : i_m1_awready;
    assign w_wReadySel  = (r_wTgt == TGT_CLINT) ? i_m0_wready  : i_m1_wready;
    assign w_bValidSel  = (r_wTgt == TGT_CLINT) ? i_m0_bvalid  : i_m1_bvalid;
    assign w_bRespSel   = (r_wTgt == TGT_CLINT) ? i_m0_bresp   : i_m1_bresp;
    assign w_arReadySel = (r_rTgt == TGT_CLINT) ? i_m0_arready : i_m1_arready;
    assign w_rValidSel  = (r_rTgt == TGT_CLINT) ? i_m0_rvalid  : i_m1_rvalid;
    assign w_rBeatSel   = (r_rTgt == TGT_CLINT) ? {i_m0_rdata, i_m0_rresp, i_m0_rlast}
                                                : {i_m1_rdata, i_m1_rresp, i_m1_rlast};

    always_comb begin
        w_wNext     = r_wState;
        o_s_awready = 1'b0;
        o_s_wready  = 1'b0;
        o_s_bvalid  = 1'b0;
        o_s_bresp   = AXI_RESP_OKAY;
        w_awValid   = 1'b0;
        w_wValid    = 1'b0;
        w_bPhase    = 1'b0;
        w_bOutReady = 1'b0;
        case (r_wState)
            W_IDLE: begin
                o_s_awready = ~areset;
                if (i_s_awvalid) begin
                    w_wNext = (w_awTgt == TGT_ERR) ? W_DATA : W_ADDR;
                end
            end
            W_ADDR: begin
                w_awValid = 1'b1;
                if (w_awReadySel) begin
                    w_wNext = W_DATA;
                end
            end
            W_DATA: begin
                w_bPhase   = 1'b1;
                o_s_wready = (r_wTgt == TGT_ERR) ? 1'b1 : w_wReadySel;
                w_wValid   = i_s_wvalid && (r_wTgt != TGT_ERR);
                if (i_s_wvalid && o_s_wready && i_s_wlast) begin
                    w_wNext = W_RESP;
                end
            end
            W_RESP: begin
                w_bPhase = 1'b1;
                if (r_wTgt == TGT_ERR) begin
                    o_s_bvalid = 1'b1;
                    o_s_bresp  = AXI_RESP_DECERR;
                    if (i_s_bready) begin
                        w_wNext = W_IDLE;
                    end
                end else begin
                    o_s_bvalid  = w_bHeld;
                    o_s_bresp   = w_bData;
                    w_bOutReady = i_s_bready;
                    if (w_bHeld && i_s_bready) begin
                        w_wNext = W_IDLE;
                    end
                end
            end
            default: w_wNext = W_IDLE;
        endcase
    end

    // The B buffer listens from the data phase on, so an early bvalid pulse is kept.
    assign w_bReadyPre = w_bPhase && !w_bHeld && (r_wTgt != TGT_ERR);

    clint_axi_skid #(.WIDTH(2)) u_bSkid (
        .aclk       (aclk),
        .areset     (areset),
        .i_inValid  (w_bValidSel && w_bReadyPre),
        .i_inData   (w_bRespSel),
        .o_inReady  (w_bInReady),
        .o_outValid (w_bHeld),
        .o_outData  (w_bData),
        .i_outReady (w_bOutReady)
    );

    always_comb begin
        w_rNext     = r_rState;
        o_s_arready = 1'b0;
        o_s_rvalid  = 1'b0;
        o_s_rdata   = '0;
        o_s_rresp   = AXI_RESP_OKAY;
        o_s_rlast   = 1'b0;
        w_arValid   = 1'b0;
        w_rPhase    = 1'b0;
        w_rOutReady = 1'b0;
        case (r_rState)
            R_IDLE: begin
                o_s_arready = ~areset;
                if (i_s_arvalid) begin
                    w_rNext = (w_arTgt == TGT_ERR) ? R_DATA : R_ADDR;
                end
            end
            R_ADDR: begin
                w_arValid = 1'b1;
                if (w_arReadySel) begin
                    w_rNext = R_DATA;
                end
            end
            R_DATA: begin
                if (r_rTgt == TGT_ERR) begin
                    o_s_rvalid = 1'b1;
                    o_s_rresp  = AXI_RESP_DECERR;
                    o_s_rlast  = 1'b1;
                    if (i_s_rready) begin
                        w_rNext = R_IDLE;
                    end
                end else begin
                    w_rPhase    = 1'b1;
                    o_s_rvalid  = w_rHeld;
                    o_s_rdata   = w_rBufData[34:3];
                    o_s_rresp   = w_rBufData[2:1];
                    o_s_rlast   = w_rBufData[0];
                    w_rOutReady = i_s_rready;
                    if (w_rHeld && i_s_rready && w_rBufData[0]) begin
                        w_rNext = R_IDLE;
                    end
                end
            end
            default: w_rNext = R_IDLE;
        endcase
    end

    assign w_rReadyPre = w_rPhase && w_rInReady;

    clint_axi_skid #(.WIDTH(35)) u_rSkid (
        .aclk       (aclk),
        .areset     (areset),
        .i_inValid  (w_rValidSel && w_rReadyPre),
        .i_inData   (w_rBeatSel),
        .o_inReady  (w_rInReady),
        .o_outValid (w_rHeld),
        .o_outData  (w_rBufData),
        .i_outReady (w_rOutReady)
    );

    // Steer strobes to the selected port only; shared payloads fan out to both.
    assign o_m0_awaddr  = r_awAddr;
    assign o_m1_awaddr  = r_awAddr;
    assign o_m0_awvalid = w_awValid && (r_wTgt == TGT_CLINT);
    assign o_m1_awvalid = w_awValid && (r_wTgt == TGT_MEM);
    assign o_m0_wdata   = i_s_wdata;
    assign o_m1_wdata   = i_s_wdata;
    assign o_m0_wlast   = i_s_wlast;
    assign o_m1_wlast   = i_s_wlast;
    assign o_m0_wvalid  = w_wValid && (r_wTgt == TGT_CLINT);
    assign o_m1_wvalid  = w_wValid && (r_wTgt == TGT_MEM);
    assign o_m0_bready  = w_bReadyPre && (r_wTgt == TGT_CLINT);
    assign o_m1_bready  = w_bReadyPre && (r_wTgt == TGT_MEM);
    assign o_m0_araddr  = r_arAddr;
    assign o_m1_araddr  = r_arAddr;
    assign o_m0_arvalid = w_arValid && (r_rTgt == TGT_CLINT);
    assign o_m1_arvalid = w_arValid && (r_rTgt == TGT_MEM);
    assign o_m0_rready  = w_rReadyPre && (r_rTgt == TGT_CLINT);
    assign o_m1_rready  = w_rReadyPre && (r_rTgt == TGT_MEM);

    logic w_unusedBInReady;
    assign w_unusedBInReady = w_bInReady;

endmodule

// File: tb/tb_clint_axi_router.sv
// Directed bench for clint_axi_router; the two slaves are driven by hand step by step.
module tb_clint_axi_router;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
    logic        m0_awvalid, m0_awready, m0_wlast, m0_wvalid, m0_wready;
    logic [1:0]  m0_bresp, m0_rresp;
    logic        m0_bvalid, m0_bready, m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic        m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready;
    logic [1:0]  m1_bresp, m1_rresp;
    logic        m1_bvalid, m1_bready, m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready;

    int   errors = 0;
    int   checks = 0;
    int   sent;
    int   recv;
    logic clintIpi1;

    clint_axi_router dut (
        .aclk(aclk), .areset(areset),
        .i_s_awaddr(s_awaddr), .i_s_awvalid(s_awvalid), .o_s_awready(s_awready),
        .i_s_wdata(s_wdata), .i_s_wlast(s_wlast), .i_s_wvalid(s_wvalid), .o_s_wready(s_wready),
        .o_s_bresp(s_bresp), .o_s_bvalid(s_bvalid), .i_s_bready(s_bready),
        .i_s_araddr(s_araddr), .i_s_arvalid(s_arvalid), .o_s_arready(s_arready),
        .o_s_rdata(s_rdata), .o_s_rresp(s_rresp), .o_s_rlast(s_rlast), .o_s_rvalid(s_rvalid),
        .i_s_rready(s_rready),
        .o_m0_awaddr(m0_awaddr), .o_m0_awvalid(m0_awvalid), .i_m0_awready(m0_awready),
        .o_m0_wdata(m0_wdata), .o_m0_wlast(m0_wlast), .o_m0_wvalid(m0_wvalid), .i_m0_wready(m0_wready),
        .i_m0_bresp(m0_bresp), .i_m0_bvalid(m0_bvalid), .o_m0_bready(m0_bready),
        .o_m0_araddr(m0_araddr), .o_m0_arvalid(m0_arvalid), .i_m0_arready(m0_arready),
        .i_m0_rdata(m0_rdata), .i_m0_rresp(m0_rresp), .i_m0_rlast(m0_rlast), .i_m0_rvalid(m0_rvalid),
        .o_m0_rready(m0_rready),
        .o_m1_awaddr(m1_awaddr), .o_m1_awvalid(m1_awvalid), .i_m1_awready(m1_awready),
        .o_m1_wdata(m1_wdata), .o_m1_wlast(m1_wlast), .o_m1_wvalid(m1_wvalid), .i_m1_wready(m1_wready),
        .i_m1_bresp(m1_bresp), .i_m1_bvalid(m1_bvalid), .o_m1_bready(m1_bready),
        .o_m1_araddr(m1_araddr), .o_m1_arvalid(m1_arvalid), .i_m1_arready(m1_arready),
        .i_m1_rdata(m1_rdata), .i_m1_rresp(m1_rresp), .i_m1_rlast(m1_rlast), .i_m1_rvalid(m1_rvalid),
        .o_m1_rready(m1_rready)
    );

    always #5 aclk = ~aclk;

    // Advance one clock with the inputs as currently set; return just after the edge.
    task automatic applyStimulus();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wlast = 0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        m0_awready = 0; m0_wready = 0; m0_bresp = '0; m0_bvalid = 0; m0_arready = 0;
        m0_rdata = '0; m0_rresp = '0; m0_rlast = 0; m0_rvalid = 0;
        m1_awready = 0; m1_wready = 0; m1_bresp = '0; m1_bvalid = 0; m1_arready = 0;
        m1_rdata = '0; m1_rresp = '0; m1_rlast = 0; m1_rvalid = 0;
        clintIpi1 = 1'b0;
        applyStimulus();
        applyStimulus();

        // Reset values
        checkOutput("rst_awready", 32'(s_awready), 0);
        checkOutput("rst_arready", 32'(s_arready), 0);
        checkOutput("rst_bvalid", 32'(s_bvalid), 0);
        checkOutput("rst_rvalid", 32'(s_rvalid), 0);
        checkOutput("rst_bresp", 32'(s_bresp), 0);
        checkOutput("rst_rdata", s_rdata, 0);
        checkOutput("rst_rlast", 32'(s_rlast), 0);
        checkOutput("rst_m0_awaddr", m0_awaddr, 0);
        checkOutput("rst_m1_araddr", m1_araddr, 0);
        areset = 1'b0;
        #1;
        checkOutput("idle_awready", 32'(s_awready), 1);
        checkOutput("idle_arready", 32'(s_arready), 1);

        // 1: CLINT msip1 write
        s_awaddr = 32'h0200_0004; s_awvalid = 1;
        applyStimulus();
        s_awvalid = 0;
        #1;
        checkOutput("t1_m0_awvalid", 32'(m0_awvalid), 1);
        checkOutput("t1_m0_awaddr", m0_awaddr, 32'h0200_0004);
        checkOutput("t1_m1_awvalid", 32'(m1_awvalid), 0);
        checkOutput("t1_awready_busy", 32'(s_awready), 0);
        applyStimulus();
        checkOutput("t1_awvalid_hold", 32'(m0_awvalid), 1);
        m0_awready = 1;
        applyStimulus();
        m0_awready = 0;
        s_wdata = 32'h1; s_wlast = 1; s_wvalid = 1; m0_wready = 0;
        #1;
        checkOutput("t1_m0_awvalid_done", 32'(m0_awvalid), 0);
        checkOutput("t1_wready_stall", 32'(s_wready), 0);
        checkOutput("t1_m0_wvalid", 32'(m0_wvalid), 1);
        checkOutput("t1_m0_wdata", m0_wdata, 32'h1);
        m0_wready = 1; m0_bvalid = 1; m0_bresp = 2'b00;
        #1;
        checkOutput("t1_wready", 32'(s_wready), 1);
        checkOutput("t1_m0_bready", 32'(m0_bready), 1);
        if (m0_wvalid && m0_wready && m0_awaddr == 32'h0200_0004) clintIpi1 = m0_wdata[0];
        applyStimulus();
        s_wvalid = 0; s_wlast = 0; m0_wready = 0; m0_bvalid = 0;
        #1;
        checkOutput("t1_ipi1", 32'(clintIpi1), 1);
        checkOutput("t1_bvalid", 32'(s_bvalid), 1);
        checkOutput("t1_bresp", 32'(s_bresp), 0);
        s_bready = 1;
        applyStimulus();
        s_bready = 0;
        #1;
        checkOutput("t1_bvalid_clr", 32'(s_bvalid), 0);

        // 2: four-beat memory read with upstream back-pressure
        s_araddr = 32'h8000_0010; s_arvalid = 1;
        applyStimulus();
        s_arvalid = 0;
        #1;
        checkOutput("t2_m1_arvalid", 32'(m1_arvalid), 1);
        checkOutput("t2_m1_araddr", m1_araddr, 32'h8000_0010);
        checkOutput("t2_m0_arvalid", 32'(m0_arvalid), 0);
        m1_arready = 1;
        applyStimulus();
        m1_arready = 0;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            m1_rvalid = (sent < 4);
            m1_rdata  = 32'(32'hA0 + sent);
            m1_rlast  = (sent == 3);
            s_rready  = (cyc % 2 == 0);
            #1;
            if (s_rvalid && s_rready) begin
                checkOutput("t2_rdata", s_rdata, 32'(32'hA0 + recv));
                checkOutput("t2_rlast", 32'(s_rlast), 32'(recv == 3));
                recv++;
            end
            if (m1_rvalid && m1_rready) sent++;
            applyStimulus();
        end
        m1_rvalid = 0; m1_rlast = 0; s_rready = 0;
        #1;
        checkOutput("t2_beats", 32'(recv), 4);
        checkOutput("t2_rvalid_after", 32'(s_rvalid), 0);
        checkOutput("t2_arready_after", 32'(s_arready), 1);

        // 3: write to an unmapped address
        s_awaddr = 32'h1000_0000; s_awvalid = 1;
        applyStimulus();
        s_awvalid = 0;
        s_wdata = 32'hDEAD; s_wvalid = 1; s_wlast = 0;
        #1;
        checkOutput("t3_m0_awvalid", 32'(m0_awvalid), 0);
        checkOutput("t3_m1_awvalid", 32'(m1_awvalid), 0);
        checkOutput("t3_wready1", 32'(s_wready), 1);
        checkOutput("t3_m1_wvalid", 32'(m1_wvalid), 0);
        checkOutput("t3_m0_wvalid", 32'(m0_wvalid), 0);
        applyStimulus();
        s_wlast = 1;
        #1;
        checkOutput("t3_wready2", 32'(s_wready), 1);
        checkOutput("t3_bvalid_early", 32'(s_bvalid), 0);
        applyStimulus();
        s_wvalid = 0; s_wlast = 0;
        #1;
        checkOutput("t3_bvalid", 32'(s_bvalid), 1);
        checkOutput("t3_bresp", 32'(s_bresp), 3);
        s_bready = 1;
        applyStimulus();
        s_bready = 0;
        #1;
        checkOutput("t3_bvalid_once", 32'(s_bvalid), 0);

        // 4: read from an unmapped address, then just past the CLINT window
        s_araddr = 32'h1000_0000; s_arvalid = 1;
        applyStimulus();
        s_arvalid = 0;
        #1;
        checkOutput("t4_m0_arvalid", 32'(m0_arvalid), 0);
        checkOutput("t4_m1_arvalid", 32'(m1_arvalid), 0);
        checkOutput("t4_rvalid", 32'(s_rvalid), 1);
        checkOutput("t4_rdata", s_rdata, 0);
        checkOutput("t4_rresp", 32'(s_rresp), 3);
        checkOutput("t4_rlast", 32'(s_rlast), 1);
        s_rready = 1;
        applyStimulus();
        s_rready = 0;
        #1;
        checkOutput("t4_rvalid_once", 32'(s_rvalid), 0);
        s_araddr = 32'h0201_0000; s_arvalid = 1;
        applyStimulus();
        s_arvalid = 0;
        #1;
        checkOutput("t4b_m0_arvalid", 32'(m0_arvalid), 0);
        checkOutput("t4b_rresp", 32'(s_rresp), 3);
        s_rready = 1;
        applyStimulus();
        s_rready = 0;

        // 5: concurrent CLINT read and memory write, late bready
        s_araddr = 32'h0200_0008; s_arvalid = 1;
        s_awaddr = 32'h8000_0000; s_awvalid = 1;
        applyStimulus();
        s_arvalid = 0; s_awvalid = 0;
        #1;
        checkOutput("t5_m0_arvalid", 32'(m0_arvalid), 1);
        checkOutput("t5_m1_awvalid", 32'(m1_awvalid), 1);
        checkOutput("t5_m1_arvalid", 32'(m1_arvalid), 0);
        checkOutput("t5_m0_awvalid", 32'(m0_awvalid), 0);
        m0_arready = 1; m1_awready = 1;
        applyStimulus();
        m0_arready = 0; m1_awready = 0;
        s_wdata = 32'h55; s_wlast = 1; s_wvalid = 1; m1_wready = 1;
        m0_rvalid = 1; m0_rdata = 32'h1234; m0_rresp = 2'b00; m0_rlast = 1;
        #1;
        checkOutput("t5_m1_wvalid", 32'(m1_wvalid), 1);
        checkOutput("t5_m0_wvalid", 32'(m0_wvalid), 0);
        checkOutput("t5_m0_rready", 32'(m0_rready), 1);
        applyStimulus();
        s_wvalid = 0; s_wlast = 0; m1_wready = 0; m0_rvalid = 0; m0_rlast = 0;
        #1;
        checkOutput("t5_rvalid", 32'(s_rvalid), 1);
        checkOutput("t5_rdata", s_rdata, 32'h1234);
        checkOutput("t5_rlast", 32'(s_rlast), 1);
        checkOutput("t5_bvalid_early", 32'(s_bvalid), 0);
        s_rready = 1;
        applyStimulus();
        s_rready = 0;
        m1_bvalid = 1; m1_bresp = 2'b00;
        #1;
        checkOutput("t5_m1_bready", 32'(m1_bready), 1);
        applyStimulus();
        m1_bvalid = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("t5_bvalid_held", 32'(s_bvalid), 1);
            checkOutput("t5_m1_bready_held", 32'(m1_bready), 0);
            applyStimulus();
        end
        s_bready = 1;
        #1;
        checkOutput("t5_bresp", 32'(s_bresp), 0);
        applyStimulus();
        s_bready = 0;
        #1;
        checkOutput("t5_bvalid_once", 32'(s_bvalid), 0);

        // 6: reset in the data phase, then a clean write
        s_awaddr = 32'h0200_0000; s_awvalid = 1;
        applyStimulus();
        s_awvalid = 0;
        m0_awready = 1;
        applyStimulus();
        m0_awready = 0;
        s_wdata = 32'h0; s_wvalid = 1; s_wlast = 1; m0_wready = 0;
        #1;
        checkOutput("t6_m0_wvalid", 32'(m0_wvalid), 1);
        areset = 1;
        applyStimulus();
        checkOutput("t6_rst_m0_wvalid", 32'(m0_wvalid), 0);
        checkOutput("t6_rst_m0_awvalid", 32'(m0_awvalid), 0);
        checkOutput("t6_rst_bvalid", 32'(s_bvalid), 0);
        checkOutput("t6_rst_awready", 32'(s_awready), 0);
        areset = 0; s_wvalid = 0; s_wlast = 0;
        s_awaddr = 32'h0200_0000; s_awvalid = 1;
        #1;
        checkOutput("t6_awready", 32'(s_awready), 1);
        applyStimulus();
        s_awvalid = 0;
        m0_awready = 1;
        applyStimulus();
        m0_awready = 0;
        s_wdata = 32'h1; s_wvalid = 1; s_wlast = 1; m0_wready = 1; m0_bvalid = 1; m0_bresp = 2'b00;
        applyStimulus();
        s_wvalid = 0; s_wlast = 0; m0_wready = 0; m0_bvalid = 0;
        #1;
        checkOutput("t6_bvalid", 32'(s_bvalid), 1);
        checkOutput("t6_bresp", 32'(s_bresp), 0);
        s_bready = 1;
        applyStimulus();
        s_bready = 0;
        #1;
        checkOutput("t6_bvalid_clr", 32'(s_bvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
